// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// uart_rx_param
// Parametrised UART receiver: configurable data width, parity mode, stop-bit
// count and baud divisor. Reports parity, framing, break and overrun errors, and
// offers a level-valid/acknowledge handshake toward the consumer.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_uart       serial line (idle high, asynchronous to i_clk)
//   i_read_ack   one-cycle consumer acknowledge; clears o_read_flag/o_overrun
//   o_bin        received data word (LSB first on the line)
//   o_read_flag  new frame available, held until acknowledged
//   o_parity_err parity mismatch for the frame in o_bin
//   o_frame_err  a stop bit was sampled low for the frame in o_bin
//   o_break      frame was a break (data, parity and first stop all low)
//   o_overrun    sticky: a frame completed while o_read_flag was still high
module uart_rx_param #(
  parameter int CLK_FREQ    = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart,
  input  logic                 i_read_ack,
  output logic [DATA_BITS-1:0] o_bin,
  output logic                 o_read_flag,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_t               state_q, state_n;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_n;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_acc_q, par_acc_n;
  logic                 zero_q, zero_n;
  logic                 ferr_q, ferr_n;
  logic                 commit;
  logic                 tick_full;
  logic                 par_err;

  assign rx_s = sync_q[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[0], i_uart};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
      zero_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      clk_cnt_q <= clk_cnt_n;
      bit_idx_q <= bit_idx_n;
      shift_q   <= shift_n;
      par_acc_q <= par_acc_n;
      zero_q    <= zero_n;
      ferr_q    <= ferr_n;
    end
  end

  assign tick_full = (clk_cnt_q == CNT_FULL);

  always_comb begin
    state_n   = state_q;
    clk_cnt_n = clk_cnt_q;
    bit_idx_n = bit_idx_q;
    shift_n   = shift_q;
    par_acc_n = par_acc_q;
    zero_n    = zero_q;
    ferr_n    = ferr_q;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          par_acc_n = 1'b0;
          zero_n    = 1'b1;
          ferr_n    = 1'b0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_n = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick_full) begin
          clk_cnt_n = '0;
          // Shifting in from the top leaves the first (LSB) bit at index 0
          // after DATA_BITS samples, same as writing shift[bit_idx].
          shift_n   = {rx_s, shift_q[DATA_BITS-1:1]};
          par_acc_n = par_acc_q ^ rx_s;
          zero_n    = zero_q & ~rx_s;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_n = '0;
            state_n   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_n = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick_full) begin
          clk_cnt_n = '0;
          par_acc_n = par_acc_q ^ rx_s;
          zero_n    = zero_q & ~rx_s;
          state_n   = S_STOP;
        end else begin
          clk_cnt_n = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick_full) begin
          clk_cnt_n = '0;
          ferr_n    = ferr_q | ~rx_s;
          // Only the first stop bit takes part in break detection.
          if (bit_idx_q == '0) zero_n = zero_q & ~rx_s;
          if (bit_idx_q == LAST_STOP) begin
            commit    = 1'b1;
            bit_idx_n = '0;
            state_n   = zero_n ? S_BREAK_WAIT : S_IDLE;
          end else begin
            bit_idx_n = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt_q + 1'b1;
        end
      end
      S_BREAK_WAIT: begin
        clk_cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    par_err = 1'b0;
    if (PARITY_MODE == 1)      par_err = ~par_acc_q;
    else if (PARITY_MODE == 2) par_err = par_acc_q;
  end

  // A commit in the same cycle as an acknowledge keeps the flag set and
  // clears overrun; overrun only rises when an unacknowledged frame is lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bin        <= '0;
      o_read_flag  <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (commit) begin
      o_bin        <= shift_q;
      o_parity_err <= par_err;
      o_frame_err  <= ferr_n;
      o_break      <= zero_n;
      o_read_flag  <= 1'b1;
      if (o_read_flag && !i_read_ack) o_overrun <= 1'b1;
      else if (i_read_ack)            o_overrun <= 1'b0;
    end else if (i_read_ack) begin
      o_read_flag <= 1'b0;
      o_overrun   <= 1'b0;
    end
  end

endmodule
